// File: rtl/dmem_arbiter_if.sv
// Bundles the two requester ports (cpu, dbg), the data-memory port and the
// error flag of the data-memory arbiter. The arbiter takes the slave side;
// requesters and the memory model take the master side.
interface dmem_arbiter_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32
);
   logic              cpu_req;
   logic              cpu_we;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_wdata;
   logic [DATA_W-1:0] cpu_rdata;
   logic              cpu_ack;

   logic              dbg_req;
   logic              dbg_we;
   logic [ADDR_W-1:0] dbg_addr;
   logic [DATA_W-1:0] dbg_wdata;
   logic [DATA_W-1:0] dbg_rdata;
   logic              dbg_ack;

   logic              mem_rd;
   logic              mem_wr;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   logic              err;

   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
      output cpu_rdata, cpu_ack,
      input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
      output dbg_rdata, dbg_ack,
      output mem_rd, mem_wr, mem_addr, mem_wdata,
      input  mem_rdata,
      output err
   );

   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata,
      input  cpu_rdata, cpu_ack,
      output dbg_req, dbg_we, dbg_addr, dbg_wdata,
      input  dbg_rdata, dbg_ack,
      input  mem_rd, mem_wr, mem_addr, mem_wdata,
      output mem_rdata,
      input  err
   );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-requester (cpu, dbg) round-robin arbiter in front of a single-port data
// memory. One access is in flight at a time: IDLE picks a winner and latches
// its request, ISSUE strobes the memory for one cycle, CAPTURE registers read
// data, ACK pulses the winner's ack. Out-of-range accesses skip the memory and
// go straight to ACK with err raised.
module dmem_arbiter #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 32,
   parameter int MEM_LAST = 10
) (
   input logic            clk,
   input logic            reset,
   dmem_arbiter_if.slave  bus
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_LAST);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      CAPTURE,
      ACK
   } state_t;

   state_t            state;
   state_t            state_next;

   // Latched access: winner id, direction, address, data, range result
   logic              win_dbg;
   logic              lat_we;
   logic [ADDR_W-1:0] lat_addr;
   logic [DATA_W-1:0] lat_wdata;
   logic              lat_oor;

   // Round-robin memory: 1 means dbg was served most recently
   logic              last_dbg;

   logic [DATA_W-1:0] cpu_rdata_q;
   logic [DATA_W-1:0] dbg_rdata_q;

   // Candidate access as selected by the arbiter this cycle
   logic              any_req;
   logic              pick_dbg;
   logic              pick_we;
   logic [ADDR_W-1:0] pick_addr;
   logic [DATA_W-1:0] pick_wdata;
   logic              pick_oor;
   logic              grant;

   // Round-robin choice between the requesters, then mux the winner's fields
   always_comb begin
      any_req    = bus.cpu_req | bus.dbg_req;
      pick_dbg   = 1'b0;
      pick_we    = 1'b0;
      pick_addr  = '0;
      pick_wdata = '0;
      if (bus.cpu_req && bus.dbg_req) begin
         pick_dbg = ~last_dbg;
      end else begin
         pick_dbg = bus.dbg_req;
      end
      if (pick_dbg) begin
         pick_we    = bus.dbg_we;
         pick_addr  = bus.dbg_addr;
         pick_wdata = bus.dbg_wdata;
      end else begin
         pick_we    = bus.cpu_we;
         pick_addr  = bus.cpu_addr;
         pick_wdata = bus.cpu_wdata;
      end
      pick_oor = (pick_addr > LAST_ADDR);
      grant    = (state == IDLE) && any_req;
   end

   // State register; reset drops any access in flight straight back to IDLE
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic for the access sequence
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (any_req) begin
               state_next = pick_oor ? ACK : ISSUE;
            end
         end
         ISSUE: begin
            state_next = lat_we ? ACK : CAPTURE;
         end
         CAPTURE: begin
            state_next = ACK;
         end
         ACK: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Latch the winning request so later input changes cannot disturb it,
   // and remember who was served for the next contested arbitration
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         win_dbg   <= 1'b0;
         lat_we    <= 1'b0;
         lat_addr  <= '0;
         lat_wdata <= '0;
         lat_oor   <= 1'b0;
         last_dbg  <= 1'b1;
      end else if (grant) begin
         win_dbg   <= pick_dbg;
         lat_we    <= pick_we;
         lat_addr  <= pick_addr;
         lat_wdata <= pick_wdata;
         lat_oor   <= pick_oor;
         last_dbg  <= pick_dbg;
      end
   end

   // Per-requester read data: memory data in CAPTURE, zero for an
   // out-of-range read; the non-winning register always holds
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cpu_rdata_q <= '0;
         dbg_rdata_q <= '0;
      end else if (grant && pick_oor && !pick_we) begin
         if (pick_dbg) begin
            dbg_rdata_q <= '0;
         end else begin
            cpu_rdata_q <= '0;
         end
      end else if (state == CAPTURE) begin
         if (win_dbg) begin
            dbg_rdata_q <= bus.mem_rdata;
         end else begin
            cpu_rdata_q <= bus.mem_rdata;
         end
      end
   end

   // Memory strobes and bus only in ISSUE; ack and err only in ACK
   always_comb begin
      bus.mem_rd    = 1'b0;
      bus.mem_wr    = 1'b0;
      bus.mem_addr  = '0;
      bus.mem_wdata = '0;
      bus.cpu_ack   = 1'b0;
      bus.dbg_ack   = 1'b0;
      bus.err       = 1'b0;
      case (state)
         ISSUE: begin
            bus.mem_addr  = lat_addr;
            bus.mem_wdata = lat_wdata;
            bus.mem_wr    = lat_we;
            bus.mem_rd    = ~lat_we;
         end
         ACK: begin
            bus.cpu_ack = ~win_dbg;
            bus.dbg_ack = win_dbg;
            bus.err     = lat_oor;
         end
         default: begin
         end
      endcase
   end

   assign bus.cpu_rdata = cpu_rdata_q;
   assign bus.dbg_rdata = dbg_rdata_q;

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter: DATA_W, default 32, width of data words on all ports.
REQ-002 Parameter: ADDR_W, default 32, width of all address ports.
REQ-003 Parameter: MEM_LAST, default 10, highest legal word address of the data memory.
REQ-004 Port: clk  in  1  clock; all state changes on its rising edge.
REQ-005 Port: reset  in  1  reset, asynchronous, active-high.
REQ-006 Ports: cpu_req, cpu_we  in  1 each  CPU access request and write select (1=write, 0=read).
REQ-007 Ports: cpu_addr  in  ADDR_W; cpu_wdata  in  DATA_W  CPU word address and write data.
REQ-008 Ports: cpu_rdata  out  DATA_W; cpu_ack  out  1  CPU read data (registered) and completion pulse.
REQ-009 Ports: dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_rdata, dbg_ack  same widths and meaning as the cpu_* ports, for the debug/loader requester.
REQ-010 Ports: mem_rd, mem_wr  out  1 each  read and write strobes to the data memory.
REQ-011 Ports: mem_addr  out  ADDR_W; mem_wdata  out  DATA_W; mem_rdata  in  DATA_W  data-memory address, write data and read data (read data valid the cycle after mem_rd is sampled).
REQ-012 Port: err  out  1  one-cycle pulse, coincident with ack, flagging an out-of-range access.

Function
REQ-013 FSM states SHALL be IDLE, ISSUE, CAPTURE, ACK.
REQ-014 IDLE: no request -> stay; one or more requests -> latch winner id, we, addr and wdata, then go to ISSUE, or to ACK if latched addr > MEM_LAST.
REQ-015 Arbitration SHALL be round-robin: sole requester wins; both requesting -> the one not served last wins; the last-served pointer updates on entry to ISSUE/ACK.
REQ-016 ISSUE: drive mem_addr/mem_wdata from latched values, mem_wr=1 for a write, or mem_rd=1 for a read, for exactly one cycle; write -> ACK, read -> CAPTURE.
REQ-017 CAPTURE: load mem_rdata into the winner's rdata register at the closing edge; the other rdata register SHALL hold; -> ACK.
REQ-018 ACK: the winner's ack=1 for exactly one cycle; err=1 only for an out-of-range access; -> IDLE.
REQ-019 Latency from req first sampled in IDLE to ack: write 2 cycles, read 3 cycles, out-of-range 1 cycle.
REQ-020 Out-of-range access: no mem_rd/mem_wr asserted; for a read, the winner's rdata SHALL load 0.
REQ-021 Requester rule: req, we, addr and wdata held stable until ack; req deasserted the cycle after ack, or kept high to start a new access, which IDLE re-arbitrates.
REQ-022 Latched inputs SHALL be used during ISSUE; input changes after the IDLE sample SHALL have no effect on the access in flight.
REQ-023 mem_rd and mem_wr SHALL never be high simultaneously and SHALL be 0 outside ISSUE; mem_addr/mem_wdata SHALL be 0 outside ISSUE.
REQ-024 cpu_ack and dbg_ack SHALL never be high in the same cycle.

Reset
REQ-025 Reset SHALL force IDLE immediately, including mid-access, and abort any access in flight without an ack.
REQ-026 Reset values: cpu_rdata=0, dbg_rdata=0, cpu_ack=0, dbg_ack=0, err=0, mem_rd=0, mem_wr=0, mem_addr=0, mem_wdata=0.
REQ-027 Reset SHALL set the last-served pointer to dbg, so the CPU wins the first contested arbitration.

Verification
REQ-028 After reset, CPU read addr 4 (memory reset-filled with 3) -> mem_rd pulse in cycle 1, cpu_ack in cycle 3, cpu_rdata=3, dbg_rdata=0.
REQ-029 dbg write addr 2 data 0xA5, then CPU read addr 2 -> dbg_ack in cycle 2 with mem_wr one cycle, then cpu_rdata=0xA5.
REQ-030 cpu_req and dbg_req both held high from reset release -> served in order CPU, dbg, CPU, dbg; acks never overlap.
REQ-031 CPU read addr 11 (MEM_LAST+1) -> no mem strobes, cpu_ack and err high in cycle 1, cpu_rdata=0.
REQ-032 Reset asserted during CAPTURE of a dbg read -> outputs zero immediately, no dbg_ack, and the next dbg_req completes normally.
REQ-033 CPU changes cpu_addr from 3 to 7 one cycle after its read request is sampled -> the memory sees addr 3.
